// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the memory-port arbiter.
package mem_arb_pkg;

  localparam int unsigned DEF_ADDR_WIDTH     = 64;
  localparam int unsigned DEF_DATA_WIDTH     = 64;
  localparam int unsigned DEF_STARVE_LIMIT   = 2;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_LSU = 1'b1
  } arb_owner_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner select between IF and LSU. LSU normally wins; after STARVE_LIMIT
// consecutive LSU grants with IF waiting, IF is forced through.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic clk,
  input  logic rst,
  input  logic arb_en,
  input  logic if_req,
  input  logic lsu_req,
  output logic if_win,
  output logic lsu_win
);

  localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0] starve_cnt;
  logic          lsu_ok;

  // Combinational winner. The counter only saturates while IF is waiting,
  // so the !if_req term just keeps LSU from stalling if IF ever withdraws.
  always_comb begin
    lsu_ok  = (starve_cnt < CW'(STARVE_LIMIT)) || !if_req;
    lsu_win = arb_en && lsu_req && lsu_ok;
    if_win  = arb_en && if_req && !lsu_win;
  end

  // Consecutive-LSU-grants-while-IF-waits counter, saturating.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (lsu_win) begin
      if (!if_req)
        starve_cnt <= '0;
      else if (starve_cnt < CW'(STARVE_LIMIT))
        starve_cnt <= starve_cnt + 1'b1;
    end else if (if_win) begin
      starve_cnt <= '0;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter sharing one memory port between IF and LSU.
// Optional watchdog: define MEM_ARB_TIMEOUT_EN to enable err_o.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int unsigned STARVE_LIMIT   = DEF_STARVE_LIMIT,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    if_req_i,
  input  logic [ADDR_WIDTH-1:0]   if_addr_i,
  output logic                    if_gnt_o,
  output logic                    if_rvalid_o,
  output logic [DATA_WIDTH-1:0]   if_rdata_o,
  input  logic                    lsu_req_i,
  input  logic                    lsu_we_i,
  input  logic [ADDR_WIDTH-1:0]   lsu_addr_i,
  input  logic [DATA_WIDTH-1:0]   lsu_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] lsu_be_i,
  output logic                    lsu_gnt_o,
  output logic                    lsu_rvalid_o,
  output logic [DATA_WIDTH-1:0]   lsu_rdata_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  input  logic                    mem_gnt_i,
  input  logic                    mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  output logic                    busy_o,
  output logic                    err_o
);

  arb_state_e state, state_nxt;
  arb_owner_e owner;
  logic       arb_en, if_win, lsu_win, timeout, rsp_fire;

  // Arbitration only happens in IDLE and never while reset is asserted.
  assign arb_en = (state == IDLE) && !rst_i;

  mem_arb_pick #(.STARVE_LIMIT(STARVE_LIMIT)) u_pick (
    .clk     (clk_i),
    .rst     (rst_i),
    .arb_en  (arb_en),
    .if_req  (if_req_i),
    .lsu_req (lsu_req_i),
    .if_win  (if_win),
    .lsu_win (lsu_win)
  );

  assign if_gnt_o  = if_win;
  assign lsu_gnt_o = lsu_win;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] to_cnt;
  logic          err_q;

  // Cycles spent in REQ+RSP; zero in IDLE so every transaction starts fresh.
  always_ff @(posedge clk_i) begin
    if (rst_i || state == IDLE) to_cnt <= '0;
    else                        to_cnt <= to_cnt + 1'b1;
  end

  // A response arriving in the last allowed cycle still completes normally.
  assign timeout = (state != IDLE) && (to_cnt == TW'(TIMEOUT_CYCLES - 1)) &&
                   !((state == RSP) && mem_rvalid_i);

  // Sticky error, cleared only by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i)        err_q <= 1'b0;
    else if (timeout) err_q <= 1'b1;
  end

  assign err_o = err_q;
`else
  logic to_unused;
  assign to_unused = (TIMEOUT_CYCLES != 0);
  assign timeout   = 1'b0;
  assign err_o     = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state: grant -> REQ -> mem gnt -> RSP -> mem rvalid -> IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (if_win || lsu_win) state_nxt = REQ;
      REQ: begin
        if (timeout)        state_nxt = IDLE;
        else if (mem_gnt_i) state_nxt = RSP;
      end
      RSP: if (mem_rvalid_i || timeout) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Capture the winner's fields at grant; they stay put until the next grant.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      owner       <= OWN_IF;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      mem_be_o    <= '0;
    end else if (lsu_win) begin
      owner       <= OWN_LSU;
      mem_we_o    <= lsu_we_i;
      mem_addr_o  <= lsu_addr_i;
      mem_wdata_o <= lsu_wdata_i;
      mem_be_o    <= lsu_be_i;
    end else if (if_win) begin
      owner       <= OWN_IF;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= if_addr_i;
      mem_wdata_o <= '0;
      mem_be_o    <= '1;
    end
  end

  // Response routing to whichever requester owns the transaction.
  assign mem_req_o    = (state == REQ);
  assign rsp_fire     = (state == RSP) && mem_rvalid_i && !rst_i;
  assign if_rvalid_o  = rsp_fire && (owner == OWN_IF);
  assign lsu_rvalid_o = rsp_fire && (owner == OWN_LSU);
  assign if_rdata_o   = mem_rdata_i;
  assign lsu_rdata_o  = mem_rdata_i;
  assign busy_o       = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed cases, then randomized
// IF/LSU traffic against a reference model of grant order and memory contents.
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam int AW = 64, DW = 64, BW = DW/8, SL = 2, TO = 8, NTX = 40;
  localparam logic [AW-1:0] BASE = 64'h8000_0000;

  logic          clk = 1'b0, rst = 1'b1;
  logic          if_req = 0, if_gnt, if_rvalid;
  logic [AW-1:0] if_addr = '0;
  logic [DW-1:0] if_rdata;
  logic          lsu_req = 0, lsu_we = 0, lsu_gnt, lsu_rvalid;
  logic [AW-1:0] lsu_addr = '0;
  logic [DW-1:0] lsu_wdata = '0, lsu_rdata;
  logic [BW-1:0] lsu_be = '0;
  logic          mem_req, mem_we, mem_gnt = 0, mem_rvalid = 0;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata = '0;
  logic [BW-1:0] mem_be;
  logic          busy, err;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(SL), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_i(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
    .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
    .lsu_req_i(lsu_req), .lsu_we_i(lsu_we), .lsu_addr_i(lsu_addr),
    .lsu_wdata_i(lsu_wdata), .lsu_be_i(lsu_be), .lsu_gnt_o(lsu_gnt),
    .lsu_rvalid_o(lsu_rvalid), .lsu_rdata_o(lsu_rdata),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_be_o(mem_be),
    .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
    .busy_o(busy), .err_o(err)
  );

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic smp();  @(negedge clk);    endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] wd,
                                          input logic [BW-1:0] be);
    logic [DW-1:0] r = old;
    for (int b = 0; b < BW; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // Reference state for the random phase.
  logic [DW-1:0] ref_mem [4];
  logic [DW-1:0] sim_mem [4];
  logic          run = 1'b0, resp_now = 1'b0;
  logic          exp_lsu = 1'b0, exp_we = 1'b0;
  logic [AW-1:0] exp_addr = '0;
  logic [DW-1:0] exp_wdata = '0, exp_rdata = '0;
  logic [BW-1:0] exp_be = '0;

  // Checks grant order (LSU first, IF after SL LSU grants in a row while it waits),
  // response routing and read data against ref_mem.
  task automatic monitor();
    bit         m_busy = 0;
    int         streak = 0;
    logic [1:0] expg;
    logic [1:0] idx;
    while (run) begin
      @(negedge clk);
      expg = 2'b00;
      if (!m_busy) begin
        if (lsu_req && (streak < SL || !if_req)) expg = 2'b01;
        else if (if_req)                         expg = 2'b10;
      end
      chk("gnt", {62'd0, if_gnt, lsu_gnt}, {62'd0, expg});
      if (expg == 2'b01) begin
        streak = if_req ? ((streak < SL) ? streak + 1 : SL) : 0;
        exp_lsu = 1; exp_we = lsu_we; exp_addr = lsu_addr; exp_wdata = lsu_wdata; exp_be = lsu_be;
        idx = lsu_addr[4:3];
        if (lsu_we) ref_mem[idx] = merge(ref_mem[idx], lsu_wdata, lsu_be);
        else        exp_rdata = ref_mem[idx];
        m_busy = 1;
      end else if (expg == 2'b10) begin
        streak = 0;
        exp_lsu = 0; exp_we = 0; exp_addr = if_addr;
        idx = if_addr[4:3];
        exp_rdata = ref_mem[idx];
        m_busy = 1;
      end
      chk("if_rv",  {63'd0, if_rvalid},  {63'd0, resp_now && !exp_lsu});
      chk("lsu_rv", {63'd0, lsu_rvalid}, {63'd0, resp_now && exp_lsu});
      if (resp_now) begin
        if (!exp_lsu)     chk("if_rdata", if_rdata, exp_rdata);
        else if (!exp_we) chk("lsu_rdata", lsu_rdata, exp_rdata);
        m_busy = 0;
      end
    end
  endtask

  // Memory model: random gnt/rvalid latency, stray rvalid pulses while in REQ.
  task automatic responder();
    int         d;
    logic [1:0] idx;
    while (run) begin
      @(negedge clk);
      if (mem_req) begin
        chk("m_addr", mem_addr, exp_addr);
        chk("m_we", {63'd0, mem_we}, {63'd0, exp_we});
        if (exp_lsu) chk("m_be", {56'd0, mem_be}, {56'd0, exp_be});
        if (exp_we)  chk("m_wdata", mem_wdata, exp_wdata);
        d = $urandom_range(0, 3);
        for (int i = 0; i < d; i++) begin
          tick();
          mem_rvalid = ($urandom_range(0, 2) == 0);
          mem_rdata  = {$urandom, $urandom};
          smp();
          chk("m_hold", {63'd0, mem_req}, 64'd1);
          chk("m_addr_hold", mem_addr, exp_addr);
        end
        tick(); mem_rvalid = 0; mem_gnt = 1;
        tick(); mem_gnt = 0;
        d = $urandom_range(0, 3);
        repeat (d) @(posedge clk);
        #1;
        idx = mem_addr[4:3];
        if (mem_we) begin
          sim_mem[idx] = merge(sim_mem[idx], mem_wdata, mem_be);
          mem_rdata = {$urandom, $urandom};
        end else begin
          mem_rdata = sim_mem[idx];
        end
        mem_rvalid = 1; resp_now = 1;
        tick(); mem_rvalid = 0; resp_now = 0;
      end
    end
  endtask

  task automatic if_drv();
    int t;
    for (int n = 0; n < NTX; n++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      tick();
      if_req = 1; if_addr = BASE + 64'($urandom_range(0, 3) * 8);
      t = 0;
      do begin smp(); t++; end while (!if_gnt && t < 200);
      if (!if_gnt) begin chk("if_gnt_timeout", 0, 1); if_req = 0; return; end
      tick(); if_req = 0; if_addr = {$urandom, $urandom};
      t = 0;
      do begin smp(); t++; end while (!if_rvalid && t < 200);
      if (!if_rvalid) begin chk("if_rv_timeout", 0, 1); return; end
    end
  endtask

  task automatic lsu_drv();
    int t;
    for (int n = 0; n < NTX; n++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      tick();
      lsu_req = 1; lsu_we = $urandom_range(0, 1) == 1;
      lsu_addr = BASE + 64'($urandom_range(0, 3) * 8);
      lsu_wdata = {$urandom, $urandom}; lsu_be = BW'($urandom_range(1, 255));
      t = 0;
      do begin smp(); t++; end while (!lsu_gnt && t < 200);
      if (!lsu_gnt) begin chk("lsu_gnt_timeout", 0, 1); lsu_req = 0; return; end
      tick(); lsu_req = 0; lsu_addr = {$urandom, $urandom}; lsu_wdata = '0;
      t = 0;
      do begin smp(); t++; end while (!lsu_rvalid && t < 200);
      if (!lsu_rvalid) begin chk("lsu_rv_timeout", 0, 1); return; end
    end
  endtask

  initial begin
    #500_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] got;
    logic [1:0] order [6] = '{2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b10};

    // Reset state.
    tick(); tick();
    smp();
    chk("rst_flags", {56'd0, mem_req, mem_we, if_gnt, lsu_gnt, if_rvalid, lsu_rvalid, busy, err}, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_be", {56'd0, mem_be}, 0);
    tick(); rst = 0;

    // IF read, minimum latency.
    if_req = 1; if_addr = 64'h8000_0000;
    smp(); chk("t1_if_gnt", {63'd0, if_gnt}, 1); chk("t1_lsu_gnt", {63'd0, lsu_gnt}, 0);
    tick(); if_req = 0; if_addr = 64'hFFFF_0000; mem_gnt = 1;
    smp(); chk("t1_mreq", {63'd0, mem_req}, 1); chk("t1_maddr", mem_addr, 64'h8000_0000);
    chk("t1_mwe", {63'd0, mem_we}, 0); chk("t1_busy", {63'd0, busy}, 1);
    tick(); mem_gnt = 0; mem_rvalid = 1; mem_rdata = 64'h13;
    smp(); chk("t1_if_rv", {63'd0, if_rvalid}, 1); chk("t1_rdata", if_rdata, 64'h13);
    chk("t1_lsu_rv", {63'd0, lsu_rvalid}, 0);
    tick(); mem_rvalid = 0;
    smp(); chk("t1_idle", {63'd0, busy}, 0);

    // LSU write with memory stalling 5 cycles; IF waits and must not be granted.
    tick(); lsu_req = 1; lsu_we = 1; lsu_addr = 64'h8000_1000; lsu_be = 8'h0F;
    lsu_wdata = 64'hDEAD_BEEF;
    smp(); chk("t2_lsu_gnt", {63'd0, lsu_gnt}, 1); chk("t2_if_gnt", {63'd0, if_gnt}, 0);
    tick(); lsu_req = 0; lsu_addr = '0; lsu_wdata = '0; lsu_be = '0;
    if_req = 1; if_addr = 64'h8000_0008;
    for (int i = 0; i < 5; i++) begin
      smp();
      chk("t2_mreq", {63'd0, mem_req}, 1);
      chk("t2_mwe", {63'd0, mem_we}, 1);
      chk("t2_maddr", mem_addr, 64'h8000_1000);
      chk("t2_mbe", {56'd0, mem_be}, 64'h0F);
      chk("t2_mwdata", mem_wdata, 64'hDEAD_BEEF);
      chk("t2_no_gnt", {62'd0, if_gnt, lsu_gnt}, 0);
    end
    tick(); mem_gnt = 1; if_req = 0;
    smp(); chk("t2_mreq_g", {63'd0, mem_req}, 1);
    tick(); mem_gnt = 0; mem_rvalid = 1; mem_rdata = 64'h1234;
    smp(); chk("t2_lsu_rv", {63'd0, lsu_rvalid}, 1); chk("t2_if_rv", {63'd0, if_rvalid}, 0);
    tick(); mem_rvalid = 0;

    // Both request continuously: L L I L L I.
    if_req = 1; if_addr = 64'h8000_0010;
    lsu_req = 1; lsu_we = 0; lsu_addr = 64'h8000_0020; lsu_be = 8'hFF;
    for (int k = 0; k < 6; k++) begin
      smp(); got = {if_gnt, lsu_gnt};
      chk($sformatf("t3_order%0d", k), {62'd0, got}, {62'd0, order[k]});
      tick(); mem_gnt = 1;
      tick(); mem_gnt = 0; mem_rvalid = 1;
      tick(); mem_rvalid = 0;
      if (k == 5) begin if_req = 0; lsu_req = 0; end
    end

    // Reset in RSP, then a stray response.
    if_req = 1; if_addr = 64'h8000_0040;
    smp(); chk("t4_gnt", {63'd0, if_gnt}, 1);
    tick(); if_req = 0; mem_gnt = 1;
    tick(); mem_gnt = 0; rst = 1;
    tick(); rst = 0; mem_rvalid = 1; mem_rdata = 64'h55;
    smp();
    chk("t4_flags", {58'd0, if_rvalid, lsu_rvalid, busy, mem_req, mem_we, err}, 0);
    chk("t4_addr", mem_addr, 0);
    tick(); mem_rvalid = 0;
    smp(); chk("t4_idle", {63'd0, busy}, 0);

`ifdef MEM_ARB_TIMEOUT_EN
    // Memory never answers: error after TO cycles in REQ+RSP.
    tick(); lsu_req = 1; lsu_we = 0; lsu_addr = 64'h8000_0000; lsu_be = 8'hFF;
    smp(); chk("t5_gnt", {63'd0, lsu_gnt}, 1);
    tick(); lsu_req = 0;
    for (int i = 0; i < TO; i++) begin
      smp(); chk("t5_busy", {63'd0, busy}, 1); chk("t5_err_lo", {63'd0, err}, 0);
    end
    smp(); chk("t5_err", {63'd0, err}, 1); chk("t5_idle", {63'd0, busy}, 0);
    chk("t5_mreq", {63'd0, mem_req}, 0); chk("t5_rv", {63'd0, lsu_rvalid}, 0);
    repeat (3) smp();
    chk("t5_sticky", {63'd0, err}, 1);
    tick(); rst = 1;
    tick(); rst = 0;
    smp(); chk("t5_clr", {63'd0, err}, 0);
`endif

    // Randomized traffic.
    tick(); rst = 1;
    tick(); rst = 0;
    for (int i = 0; i < 4; i++) begin
      ref_mem[i] = {$urandom, $urandom};
      sim_mem[i] = ref_mem[i];
    end
    run = 1;
    fork
      monitor();
      responder();
    join_none
    fork
      if_drv();
      lsu_drv();
    join
    repeat (4) smp();
    run = 0;
    repeat (8) smp();
    for (int i = 0; i < 4; i++) chk($sformatf("mem%0d", i), sim_mem[i], ref_mem[i]);
`ifndef MEM_ARB_TIMEOUT_EN
    chk("err_tied", {63'd0, err}, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
